// File: rtl/shift_rx8.sv
// ============================================================================
// Module      : shift_rx8
// Description : Serial-in, parallel-out byte receiver (MSB first) with a
//               valid/ack handshake, overrun flag and inactivity timeout.
//               Define SHIFT_RX8_PARITY_EN to add an odd-parity bit per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rx8 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Shift_Enable,
    input  logic       Data_In,
    input  logic       Ack,
    output logic [7:0] Data_Out,
    output logic       Valid,
    output logic       Busy,
    output logic       Overrun,
    output logic       Timeout,
    output logic       Parity_Err
);

    localparam int C_CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit C_TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [C_CW-1:0] C_TLIM = C_CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef SHIFT_RX8_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_RECV   = 2'd1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_shreg;
    logic [2:0]      r_cnt;
    logic [C_CW-1:0] r_tcnt;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_overrun;
    logic            r_timeout;
    logic            r_parity_err;

    logic [7:0]      w_shift;
    logic            w_active;
    logic            w_sample;
    logic            w_to_hit;
    logic            w_commit;
    logic [7:0]      w_commit_byte;
    logic            w_commit_perr;

    assign w_shift  = {r_shreg[6:0], Data_In};
    assign w_active = (r_state != ST_IDLE);
    // Start always wins: it discards both a coincident bit and a timeout.
    assign w_sample = w_active && Shift_Enable && !Start;
    assign w_to_hit = C_TO_EN && w_active && !Shift_Enable && !Start && (r_tcnt == C_TLIM);

    always_comb begin
        w_state_next  = r_state;
        w_commit      = 1'b0;
        w_commit_byte = w_shift;
        w_commit_perr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) w_state_next = ST_RECV;
            end
            ST_RECV: begin
                if (Start) begin
                    w_state_next = ST_RECV;
                end else if (w_sample && (r_cnt == 3'd7)) begin
`ifdef SHIFT_RX8_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_IDLE;
                    w_commit     = 1'b1;
`endif
                end else if (w_to_hit) begin
                    w_state_next = ST_IDLE;
                end
            end
`ifdef SHIFT_RX8_PARITY_EN
            ST_PARITY: begin
                w_commit_byte = r_shreg;
                w_commit_perr = ~(^r_shreg ^ Data_In);
                if (Start) begin
                    w_state_next = ST_RECV;
                end else if (w_sample) begin
                    w_state_next = ST_IDLE;
                    w_commit     = 1'b1;
                end else if (w_to_hit) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Frame-building registers: shift register, bit count, idle counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_shreg <= 8'h00;
            r_cnt   <= 3'd0;
            r_tcnt  <= '0;
        end else if (Start || w_to_hit) begin
            r_shreg <= 8'h00;
            r_cnt   <= 3'd0;
            r_tcnt  <= '0;
        end else if (w_sample) begin
            r_tcnt <= '0;
            if (r_state == ST_RECV) begin
                r_shreg <= w_shift;
                r_cnt   <= r_cnt + 3'd1;
            end
        end else if (w_active && C_TO_EN) begin
            r_tcnt <= r_tcnt + C_CW'(1);
        end
    end

    // Output side: committed byte, handshake and status flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data       <= 8'h00;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (Ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_commit) begin
                r_data       <= w_commit_byte;
                r_parity_err <= w_commit_perr;
                r_valid      <= 1'b1;
                if (r_valid && !Ack) r_overrun <= 1'b1;
            end
        end
    end

    assign Data_Out = r_data;
    assign Valid    = r_valid;
    assign Busy     = w_active;
    assign Overrun  = r_overrun;
    assign Timeout  = r_timeout;
`ifdef SHIFT_RX8_PARITY_EN
    assign Parity_Err = r_parity_err;
`else
    assign Parity_Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/shift_rx8.md
# shift_rx8

Serial-in, parallel-out byte receiver with framing, a valid/ack output handshake, overrun detection and an inactivity timeout. It is the receive-side counterpart of the team's 8-bit MSB-first parallel-load serial transmitter. It sits between a bit-serial link (driven by the same `Shift_Enable` strobe scheme) and the byte-wide consumer logic in the final-project datapath.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive idle cycles allowed mid-frame; 0 disables the timeout.
- `Clk` in 1: clock, all state on rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Start` in 1: begin (or restart) a frame.
- `Shift_Enable` in 1: sample `Data_In` this cycle.
- `Data_In` in 1: serial bit, MSB first.
- `Ack` in 1: consumer accepts `Data_Out`.
- `Data_Out` out 8: last committed byte, held until next commit.
- `Valid` out 1: `Data_Out` holds an unacknowledged byte.
- `Busy` out 1: frame in progress (state != IDLE).
- `Overrun` out 1: sticky; an unacknowledged byte was overwritten.
- `Timeout` out 1: one-cycle pulse on frame abort.
- `Parity_Err` out 1: parity result of the committed byte (0 when feature compiled out).

## Operation
- Reset values: `Data_Out`=8'h00, `Valid`=0, `Busy`=0, `Overrun`=0, `Timeout`=0, `Parity_Err`=0, state IDLE, bit count 0, timeout counter 0.
- States: IDLE, RECV, PARITY (PARITY exists only with the parity feature compiled in).
- IDLE: `Start`=1 moves to RECV and clears the shift register, bit count and timeout counter. `Shift_Enable` is ignored.
- RECV: each `Shift_Enable` cycle loads shreg <= {shreg[6:0], Data_In} and increments the 3-bit count.
- Bit 8 sampled, no parity: at that same edge `Data_Out` <= {shreg[6:0], Data_In}, `Valid` <= 1, state goes to IDLE.
- Bit 8 sampled, parity: state goes to PARITY. The next `Shift_Enable` samples the parity bit and commits the byte as above. `Parity_Err` <= ~(^byte ^ parity_bit) (odd parity).
- `Start` in RECV or PARITY restarts the frame. Partial bits are discarded, and a coincident `Shift_Enable` bit is discarded.
- `Start` with `Shift_Enable` in IDLE: `Start` wins and the bit is not sampled.
- Handshake: `Valid` stays high until a cycle with `Ack`=1, then clears at that edge. `Ack` with `Valid`=0 is ignored. `Ack` also clears `Overrun`.
- Commit while `Valid`=1 and `Ack`=0: `Data_Out` is overwritten, `Valid` stays 1, `Overrun` <= 1.
- Commit in the same cycle as `Ack`: new byte is loaded, `Valid` stays 1, `Overrun` is not set.
- Timeout: the counter increments on each RECV/PARITY cycle with `Shift_Enable`=0 and resets on `Shift_Enable`.
  - After `TIMEOUT_CYCLES` consecutive such cycles, at that edge: state goes to IDLE, partial bits are dropped, `Timeout` is 1 for the following cycle only.
  - `Data_Out`, `Valid` and `Overrun` are untouched by a timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- `Start` takes priority over timeout in the same cycle.
- `Parity_Err` is updated only on commit and is held with `Data_Out`.

## Timing
- Latency: `Valid` is high in the cycle after the edge that samples the final bit (bit 8, or the parity bit).
- `Busy` rises the cycle after `Start`. It falls the cycle after the commit or abort edge.
- Back-to-back frames: `Start` may be asserted in the first cycle `Busy`=0. No dead cycle is required beyond that.
- Minimum frame: 1 cycle for `Start` plus 8 (or 9) `Shift_Enable` cycles; `Shift_Enable` may be high every cycle.
- `Reset` mid-frame or with `Valid`=1 forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `SHIFT_RX8_PARITY_EN` defined: the PARITY state is present, frames are 9 bits, and `Parity_Err` is live.
- Not defined: frames are 8 bits, `Parity_Err` is tied to 0, and no PARITY state is built.

## Test plan
- Reset; `Start`; then bits 1,0,1,0,0,1,0,1 with `Shift_Enable` every cycle -> `Data_Out`=8'hA5 and `Valid`=1 one cycle after the 8th sample; `Busy`=0; `Overrun`=0.
- With A5 still valid and no `Ack`, receive 8'h3C -> `Data_Out`=8'h3C, `Valid`=1, `Overrun`=1. `Ack` -> `Valid`=0 and `Overrun`=0 the next cycle.
- `TIMEOUT_CYCLES`=4: `Start`, 3 bits, then 4 cycles with no `Shift_Enable` -> `Timeout` is high for exactly one cycle, `Busy`=0, `Data_Out`/`Valid` unchanged. A subsequent 8'h0F frame is received correctly.
- `Start`, 5 bits of 0, `Start` together with `Shift_Enable` (`Data_In`=0), then 8 bits of 1 -> `Data_Out`=8'hFF. Commit in the same cycle as `Ack` of a prior byte -> `Valid` stays 1, `Overrun`=0.
- `SHIFT_RX8_PARITY_EN` defined: 8'hA5 with parity bit 1 -> `Parity_Err`=0; 8'hA5 with parity bit 0 -> `Parity_Err`=1. Not defined: a 9th `Shift_Enable` after the byte is ignored and `Busy` stays 0.
- `Reset` pulsed after 4 bits with `Valid`=1 and `Overrun`=1 -> all outputs 0 before the next `Clk` edge. A new frame 8'h81 after release is received correctly.
